spi_serial_tx: RTL and testbench



---
 rtl/spi_serial_tx_if.sv | 24 ++
 rtl/spi_serial_tx.sv | 170 +++++++++++++++++
 tb/tb_spi_serial_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_serial_tx_if.sv
// Handshake and SPI pin bundle for spi_serial_tx.
// slave = transmitter side, master = the block feeding words to it.
interface spi_serial_tx_if #(
    parameter int DATA_W = 33
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              spi_clk;
    logic              spi_cs;
    logic              spi_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, spi_clk, spi_cs, spi_out, busy, frame_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, spi_clk, spi_cs, spi_out, busy, frame_done
    );
endinterface

// File: rtl/spi_serial_tx.sv
// SPI master transmitter: one DATA_W-bit word per chip-select frame,
// MSB first, spi_clk derived from clk by a half-period counter.
module spi_serial_tx #(
    parameter int DATA_W   = 33,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input logic            clk,
    input logic            rst_n,
    spi_serial_tx_if.slave bus
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int BW    = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LD  = CW'(CS_IDLE - 1);
    localparam logic [BW-1:0] BITS     = BW'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              spi_clk_q, spi_clk_d;
    logic              spi_cs_q, spi_cs_d;
    logic              spi_out_q, spi_out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              go_high;

    // Next-state and next-output logic; every output is set for the
    // state being entered so the pins come straight from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        spi_clk_d = spi_clk_q;
        spi_cs_d  = spi_cs_q;
        spi_out_d = spi_out_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        go_high   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid && ready_q) begin
                    state_d   = SETUP;
                    cnt_d     = SETUP_LD;
                    shift_d   = bus.tx_data;
                    bit_cnt_d = BITS;
                    spi_cs_d  = 1'b0;
                    spi_clk_d = 1'b0;
                    spi_out_d = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) go_high = 1'b1;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d   = LOW;
                    cnt_d     = DIV_LD;
                    spi_clk_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    if (bit_cnt_q != '0) begin
                        go_high = 1'b1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d   = GAP;
                    cnt_d     = IDLE_LD;
                    spi_cs_d  = 1'b1;
                    spi_out_d = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Rising half: present the next MSB and consume it.
        if (go_high) begin
            state_d   = HIGH;
            cnt_d     = DIV_LD;
            spi_clk_d = 1'b1;
            spi_out_d = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
        end
    end

    // State, counters and output flops; reset drops the frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            spi_clk_q <= 1'b0;
            spi_cs_q  <= 1'b1;
            spi_out_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            spi_clk_q <= spi_clk_d;
            spi_cs_q  <= spi_cs_d;
            spi_out_q <= spi_out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx_ready   = ready_q;
    assign bus.spi_clk    = spi_clk_q;
    assign bus.spi_cs     = spi_cs_q;
    assign bus.spi_out    = spi_out_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_spi_serial_tx.sv
// Bench for spi_serial_tx: timeline model per instance, receiver model
// on the SPI pins, directed and random frames on two configurations.
module tb_spi_serial_tx;

    localparam int DW = 33;
    typedef logic [DW-1:0] word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    spi_serial_tx_if #(.DATA_W(DW)) bus0 ();
    spi_serial_tx_if #(.DATA_W(DW)) bus1 ();

    spi_serial_tx #(
        .DATA_W(DW), .CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .CS_IDLE(8)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0.slave)
    );

    spi_serial_tx #(
        .DATA_W(DW), .CLK_DIV(2), .CS_SETUP(4), .CS_HOLD(4), .CS_IDLE(6)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic int p_div(int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int p_idle(int i);
        return (i == 0) ? 8 : 6;
    endfunction

    // cycles from accept to the last GAP cycle
    function automatic int flen(int i);
        return 4 + 2 * p_div(i) * DW + 4 + p_idle(i);
    endfunction

    // ph = cycles since accept (0 = idle); returns
    // {cs, spi_clk, spi_out, tx_ready, busy, frame_done}
    function automatic logic [5:0] exp_out(int ph, word_t w, int i);
        int sh_end;
        int cs_end;
        int j;
        int b;
        logic ck;
        sh_end = 4 + 2 * p_div(i) * DW;
        cs_end = sh_end + 4;
        if (ph == 0) return 6'b100100;
        if (ph <= 4) return 6'b000010;
        if (ph <= sh_end) begin
            j  = ph - 5;
            b  = j / (2 * p_div(i));
            ck = (j % (2 * p_div(i))) < p_div(i);
            return {1'b0, ck, w[DW-1-b], 3'b010};
        end
        if (ph <= cs_end) return {2'b00, w[0], 3'b010};
        return {5'b10001, (ph == cs_end + 1)};
    endfunction

    function automatic int step(int ph, logic v, int i);
        if (ph == 0) return v ? 1 : 0;
        if (ph == flen(i)) return 0;
        return ph + 1;
    endfunction

    function automatic word_t rnd_word();
        word_t w;
        w = {1'($urandom_range(0, 1)), 32'($urandom)};
        return w;
    endfunction

    int    ph [2];
    word_t mw [2];

    // Reference timeline: advances on clk, cleared by async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph[0] <= 0;
            ph[1] <= 0;
        end else begin
            ph[0] <= step(ph[0], bus0.tx_valid, 0);
            ph[1] <= step(ph[1], bus1.tx_valid, 1);
            if (ph[0] == 0 && bus0.tx_valid) mw[0] <= bus0.tx_data;
            if (ph[1] == 0 && bus1.tx_valid) mw[1] <= bus1.tx_data;
        end
    end

    int    cyc = 0;
    int    accs [2];
    int    acc_cyc [2];
    int    a2a [2];
    int    rise1 [2];
    int    falls [2];
    int    low [2];
    int    dones [2];
    int    ends [2];
    int    f_low [2];
    int    f_falls [2];
    int    f_rise [2];
    logic  f_done [2];
    word_t bits [2];
    word_t f_bits [2];
    logic  pclk [2];
    logic  pcs [2];
    word_t rx_sh [2];
    word_t rx_rd [2];
    int    rx_n [2];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // a = {cs, spi_clk, spi_out, tx_ready, busy, frame_done}
    task automatic observe(int i, logic [5:0] a, logic v, logic [5:0] e, string nm);
        chk(nm, 64'(a), 64'(e));
        if (v && a[2]) begin
            if (acc_cyc[i] >= 0) a2a[i] = cyc - acc_cyc[i];
            acc_cyc[i] = cyc;
            accs[i]++;
            falls[i] = 0;
            bits[i]  = '0;
            low[i]   = 0;
            dones[i] = 0;
            rise1[i] = -1;
        end
        if (!a[5]) low[i]++;
        if (a[4] && !pclk[i] && rise1[i] < 0) rise1[i] = cyc;
        if (!a[4] && pclk[i] && !a[5]) begin
            falls[i]++;
            bits[i]  = {bits[i][DW-2:0], a[3]};
            rx_sh[i] = {rx_sh[i][DW-2:0], a[3]};
            rx_n[i]++;
        end
        if (a[0]) dones[i]++;
        if (a[5] && !pcs[i]) begin
            f_low[i]   = low[i];
            f_falls[i] = falls[i];
            f_bits[i]  = bits[i];
            f_rise[i]  = rise1[i] - acc_cyc[i];
            f_done[i]  = a[0];
            ends[i]++;
            if (rx_n[i] == DW) rx_rd[i] = rx_sh[i];
            rx_n[i] = 0;
        end
        pclk[i] = a[4];
        pcs[i]  = a[5];
    endtask

    task automatic drive(int i, logic v, word_t d);
        if (i == 0) begin
            bus0.tx_valid = v;
            bus0.tx_data  = d;
        end else begin
            bus1.tx_valid = v;
            bus1.tx_data  = d;
        end
    endtask

    task automatic wait_acc(int i, int tgt);
        int k = 0;
        while (accs[i] < tgt && k < 600) begin
            @(posedge clk);
            k++;
        end
        chk("accept wait", 64'(accs[i] >= tgt), 64'd1);
    endtask

    task automatic wait_end(int i, int tgt);
        int k = 0;
        while (ends[i] < tgt && k < 600) begin
            @(posedge clk);
            k++;
        end
        chk("frame end wait", 64'(ends[i] >= tgt), 64'd1);
    endtask

    task automatic send(int i, word_t w);
        int tgt;
        tgt = accs[i] + 1;
        @(posedge clk);
        #1 drive(i, 1'b1, w);
        wait_acc(i, tgt);
        #1 drive(i, 1'b0, rnd_word());
    endtask

    initial begin
        word_t w1, w2, prev;
        int    t;
        for (int i = 0; i < 2; i++) begin
            accs[i] = 0; acc_cyc[i] = -1; a2a[i] = 0; rise1[i] = -1;
            falls[i] = 0; low[i] = 0; dones[i] = 0; ends[i] = 0;
            f_low[i] = 0; f_falls[i] = 0; f_rise[i] = 0; f_done[i] = 1'b0;
            bits[i] = '0; f_bits[i] = '0; pclk[i] = 1'b0; pcs[i] = 1'b1;
            rx_sh[i] = '0; rx_rd[i] = '0; rx_n[i] = 0;
        end
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        #1 rst_n = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                observe(0, {bus0.spi_cs, bus0.spi_clk, bus0.spi_out,
                            bus0.tx_ready, bus0.busy, bus0.frame_done},
                        bus0.tx_valid, exp_out(ph[0], mw[0], 0), "dut0 outputs");
                observe(1, {bus1.spi_cs, bus1.spi_clk, bus1.spi_out,
                            bus1.tx_ready, bus1.busy, bus1.frame_done},
                        bus1.tx_valid, exp_out(ph[1], mw[1], 1), "dut1 outputs");
            end
        join_none

        // model pins
        chk("model bit0 phase", 64'(exp_out(5, 33'h1_2345_6789, 0)), 64'h1a);
        chk("model hold phase", 64'(exp_out(272, 33'h1_2345_6789, 0)), 64'h0a);
        chk("model gap phase", 64'(exp_out(273, 33'h1_2345_6789, 0)), 64'h23);
        chk("model frame len", 64'(flen(0)), 64'd280);

        repeat (2) @(posedge clk);
        #1 chk("reset state", 64'({bus0.spi_cs, bus0.spi_clk, bus0.spi_out,
                                   bus0.tx_ready, bus0.busy, bus0.frame_done}),
               64'h24);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // directed frame on the default configuration
        t = ends[0] + 1;
        send(0, 33'h1_2345_6789);
        wait_end(0, t);
        chk("falls per frame", 64'(f_falls[0]), 64'd33);
        chk("bits at falls", 64'(f_bits[0]), 64'h1_2345_6789);
        chk("cs low length", 64'(f_low[0]), 64'd272);
        chk("first rise offset", 64'(f_rise[0]), 64'd5);
        chk("done at cs rise", 64'(f_done[0]), 64'd1);
        chk("rx word A", 64'(rx_rd[0]), 64'h1_2345_6789);
        repeat (12) @(posedge clk);
        chk("done pulse count", 64'(dones[0]), 64'd1);

        // boundary words
        t = ends[0] + 1;
        send(0, 33'h0_0000_0001);
        wait_end(0, t);
        chk("rx word 1", 64'(rx_rd[0]), 64'h0_0000_0001);
        t = ends[0] + 1;
        send(0, 33'h1_FFFF_FFFF);
        wait_end(0, t);
        chk("rx word ones", 64'(rx_rd[0]), 64'h1_FFFF_FFFF);

        // back-to-back with tx_valid held and tx_data churn
        w1 = rnd_word();
        w2 = rnd_word();
        t  = accs[0] + 1;
        @(posedge clk);
        #1 drive(0, 1'b1, w1);
        wait_acc(0, t);
        repeat (40) @(posedge clk);
        #1 drive(0, 1'b1, rnd_word());
        t = ends[0] + 1;
        wait_end(0, t);
        #1 drive(0, 1'b1, w2);
        chk("b2b frame1 bits", 64'(f_bits[0]), 64'(w1));
        t = accs[0] + 1;
        wait_acc(0, t);
        #1 drive(0, 1'b0, rnd_word());
        chk("accept to accept", 64'(a2a[0]), 64'd281);
        t = ends[0] + 1;
        wait_end(0, t);
        chk("b2b frame2 bits", 64'(f_bits[0]), 64'(w2));
        chk("b2b rx frame2", 64'(rx_rd[0]), 64'(w2));

        // random frames on both instances, stray valid while busy
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            w1 = rnd_word();
            w2 = rnd_word();
            t  = ends[0] + 1;
            send(0, w1);
            send(1, w2);
            repeat (50) @(posedge clk);
            #1 drive(0, 1'b1, rnd_word());
            @(posedge clk);
            #1 drive(0, 1'b0, rnd_word());
            wait_end(0, t);
            chk("rand rx dut0", 64'(rx_rd[0]), 64'(w1));
            wait_end(1, k + 1);
            chk("rand rx dut1", 64'(rx_rd[1]), 64'(w2));
            chk("rand falls dut1", 64'(f_falls[1]), 64'd33);
        end
        repeat (20) @(posedge clk);

        // async reset mid-frame
        prev = rx_rd[0];
        send(0, rnd_word());
        t = 0;
        while (falls[0] < 10 && t < 600) begin
            @(posedge clk);
            t++;
        end
        chk("tenth fall wait", 64'(falls[0] >= 10), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async reset cs/clk", 64'({bus0.spi_cs, bus0.spi_clk}), 64'h2);
        chk("async reset ready", 64'(bus0.tx_ready), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("partial frame dropped", 64'(rx_rd[0]), 64'(prev));
        w1 = rnd_word();
        t  = ends[0] + 1;
        send(0, w1);
        wait_end(0, t);
        chk("rx after reset", 64'(rx_rd[0]), 64'(w1));
        chk("cs low after reset", 64'(f_low[0]), 64'd272);

        // fast configuration
        t = ends[1] + 1;
        send(1, 33'h0_AAAA_5555);
        wait_end(1, t);
        chk("fast cs low length", 64'(f_low[1]), 64'd140);
        chk("fast falls", 64'(f_falls[1]), 64'd33);
        chk("fast rx word", 64'(rx_rd[1]), 64'h0_AAAA_5555);

        repeat (20) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
